long_multiplication: RTL and testbench
======================================

Name: long_multiplication

Overview:
- Sequential shift-and-add multiply-accumulate: computes o_product = multiplicand * multiplier + addend, one multiplier bit per clock.
- Inverse of the longDivision block. Feeding it quotient, divisor and remainder reconstructs the dividend, so the divider bench uses it as a round-trip checker.
- Also serves as a standalone low-area multiplier in the DSP filter datapaths.
- Valid/ready handshake on both the input and output sides.

Parameters:
- DATA_WIDTH, 8, width of multiplicand, multiplier and addend; product is 2*DATA_WIDTH.

Ports:
- i_clk  input  1  system clock, rising edge
- i_reset_n  input  1  asynchronous active-low reset
- i_valid  input  1  operands present on i_multiplicand/i_multiplier/i_addend
- o_ready  output  1  block can accept operands (high only in IDLE)
- i_multiplicand  input  DATA_WIDTH  unsigned multiplicand (divisor in round-trip use)
- i_multiplier  input  DATA_WIDTH  unsigned multiplier (quotient)
- i_addend  input  DATA_WIDTH  unsigned addend (remainder)
- o_valid  output  1  o_product holds a completed result
- i_ready  input  1  downstream accepts result
- o_product  output  2*DATA_WIDTH  unsigned result
- o_busy  output  1  high in RUN

Behaviour:
- One clock (i_clk); reset is asynchronous and active-low (i_reset_n).
- Reset values:
  - state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_product=0.
  - Internal registers (acc, mcand, mplier, count) = 0.
- Reset is asserted asynchronously and deasserted synchronously by the surrounding reset logic.

States:
- IDLE:
  - o_ready=1.
  - On i_valid && o_ready at a rising edge (accept edge): acc <= zero-extended i_addend; mcand <= zero-extended i_multiplicand (2*DATA_WIDTH bits); mplier <= i_multiplier; count <= 0; go to RUN.
- RUN:
  - o_ready=0, o_busy=1.
  - Each edge: if mplier[0], acc <= acc + mcand; then mcand <= mcand << 1; mplier <= mplier >> 1; count <= count + 1.
  - On the edge where count == DATA_WIDTH-1, go to DONE. Exactly DATA_WIDTH iterations.
- DONE:
  - o_valid=1, o_product=acc.
  - Operand inputs are ignored.
  - On i_valid... none; on i_ready && o_valid at an edge, go to IDLE, o_valid=0.
  - o_ready rises the following cycle; no same-cycle result/operand overlap.

Latency and timing:
- Fixed latency: o_valid is high DATA_WIDTH clocks after the accept edge, independent of operand values (no early termination).
- Throughput: at most one operation per DATA_WIDTH+2 cycles with i_ready tied high.

Arithmetic and width:
- All operands unsigned.
- Maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W. This fits in 2W bits, so overflow cannot occur and no carry-out is needed.
- mcand is 2W bits wide so that its final left shift (by W-1) never truncates.

Output registers:
- o_product is registered and equal to acc. Its value is defined only while o_valid=1, and it is stable throughout DONE under backpressure.
- Intermediate values are visible during RUN.

Boundary conditions:
- i_valid while RUN/DONE: ignored; the operands are not latched.
- i_ready low in DONE: hold o_valid and o_product indefinitely.
- Zero multiplier or zero multiplicand: result = addend, still DATA_WIDTH cycles.
- i_reset_n low mid-RUN or mid-DONE: immediate return to reset values; the partial result is discarded and no o_valid pulse occurs.
- count width is clog2(DATA_WIDTH); it is compared against DATA_WIDTH-1, so it never wraps.

Decomposition:
- Shared package/include longDivision_pkg (shared with the divider): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; default DATA_WIDTH; a clog2 function for the count width.
- Single module with no sub-module. The one natural split (a 2W-bit conditional adder) is a single expression and stays inline.

Test Plan:
- Basic: W=8, multiplicand 0x0A, multiplier 0x0C, addend 0x03 -> o_valid exactly 8 cycles after accept, o_product=0x007B; o_ready low until the cycle after the i_ready handshake.
- Extremes:
  - 0xFF*0xFF+0xFF -> 0xFF00.
  - 0x00*0xFF+0x55 -> 0x0055.
  - 0xFF*0x00+0x00 -> 0x0000.
  - All take 8 cycles.
- Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1 and o_product stays 0x007B; toggling operand inputs and i_valid has no effect; after i_ready=1, o_valid drops and o_ready=1 next cycle.
- Busy ignore: pulse i_valid with new operands during RUN -> the first result is unchanged and no second result appears.
- Reset mid-operation: deassert i_reset_n at iteration 4 -> o_valid=0, o_ready=1, o_product=0, o_busy=0 immediately (asynchronous, before the next edge); the following operation (0x0A,0x0C,0x03) gives 0x007B.
- Round-trip: random dividend/divisor (divisor≠0) pushed through longDivision, quotient/divisor/remainder fed to this block -> o_product[7:0] equals the dividend and o_product[15:8]=0, for 256 vectors.

Source files
------------

// File: rtl/longDivision_pkg.sv
// State encodings, default width and a width helper shared by the
// long division and long multiplication blocks.
package longDivision_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/long_multiplication.sv
// Sequential shift-and-add multiply-accumulate:
// o_product = multiplicand * multiplier + addend, one multiplier bit per clock.
module long_multiplication
  import longDivision_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_multiplicand,
  input  logic [DATA_WIDTH-1:0]   i_multiplier,
  input  logic [DATA_WIDTH-1:0]   i_addend,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [2*DATA_WIDTH-1:0] o_product,
  output logic                    o_busy
);

  localparam int PW = 2 * DATA_WIDTH;
  // A one-bit counter is still needed when DATA_WIDTH is 1.
  localparam int CW = (clog2(DATA_WIDTH) < 1) ? 1 : clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  state_t                  state_reg,  state_next;
  logic [PW-1:0]           acc_reg,    acc_next;
  logic [PW-1:0]           mcand_reg,  mcand_next;
  logic [DATA_WIDTH-1:0]   mplier_reg, mplier_next;
  logic [CW-1:0]           count_reg,  count_next;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    case (state_reg)
      IDLE: begin
        if (i_valid) begin
          acc_next    = PW'(i_addend);
          mcand_next  = PW'(i_multiplicand);
          mplier_next = i_multiplier;
          count_next  = '0;
          state_next  = RUN;
        end
      end
      RUN: begin
        // Always run all DATA_WIDTH iterations so latency is data-independent.
        if (mplier_reg[0]) begin
          acc_next = acc_reg + mcand_reg;
        end
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        if (count_reg == LAST_COUNT) begin
          state_next = DONE;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_ready   = (state_reg == IDLE);
  assign o_busy    = (state_reg == RUN);
  assign o_valid   = (state_reg == DONE);
  assign o_product = acc_reg;

endmodule

// File: tb/tb_long_multiplication.sv
// Randomized self-checking bench for long_multiplication against a plain
// arithmetic reference (a*b+c) and a divide/remainder round trip.
module tb_long_multiplication;

  localparam int W = 8;

  logic           i_clk = 1'b0;
  logic           i_reset_n;
  logic           i_valid;
  logic           o_ready;
  logic [W-1:0]   i_multiplicand;
  logic [W-1:0]   i_multiplier;
  logic [W-1:0]   i_addend;
  logic           o_valid;
  logic           i_ready;
  logic [2*W-1:0] o_product;
  logic           o_busy;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 i_clk = ~i_clk;

  long_multiplication #(.DATA_WIDTH(W)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .i_addend       (i_addend),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_product      (o_product),
    .o_busy         (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for o_ready, present operands for one edge, return at the negedge after accept.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int guard;
    guard = 0;
    @(negedge i_clk);
    while (!o_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    check("ready_before_accept", 32'(o_ready), 32'd1);
    i_multiplicand = a;
    i_multiplier   = b;
    i_addend       = c;
    i_valid        = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    check("ready_low_in_run", 32'(o_ready), 32'd0);
    check("busy_in_run", 32'(o_busy), 32'd1);
  endtask

  // Count clock edges after the accept edge until o_valid is seen.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk);
      lat++;
      @(negedge i_clk);
    end
  endtask

  task automatic finish_op();
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check("valid_drop_after_handshake", 32'(o_valid), 32'd0);
    check("ready_after_handshake", 32'(o_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [2*W-1:0] exp);
    int lat;
    start_op(a, b, c);
    wait_done(0, lat);
    check({tag, "_latency"}, 32'(lat), 32'(W));
    check({tag, "_product"}, 32'(o_product), 32'(exp));
    $display("op %s: %02h*%02h+%02h -> %04h (expect %04h) latency %0d",
             tag, a, b, c, o_product, exp, lat);
    finish_op();
  endtask

  function automatic logic [2*W-1:0] ref_mac(input int a, input int b, input int c);
    return (2*W)'(a * b + c);
  endfunction

  initial begin
    int lat;
    logic [W-1:0] a, b, c;
    int dividend, divisor, quot, rem;

    i_reset_n      = 1'b0;
    i_valid        = 1'b0;
    i_ready        = 1'b0;
    i_multiplicand = '0;
    i_multiplier   = '0;
    i_addend       = '0;
    #12;
    check("reset_ready", 32'(o_ready), 32'd1);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_busy", 32'(o_busy), 32'd0);
    check("reset_product", 32'(o_product), 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    run_op("basic", 8'h0A, 8'h0C, 8'h03, ref_mac(10, 12, 3));
    run_op("max", 8'hFF, 8'hFF, 8'hFF, ref_mac(255, 255, 255));
    run_op("zero_mcand", 8'h00, 8'hFF, 8'h55, ref_mac(0, 255, 85));
    run_op("zero_mplier", 8'hFF, 8'h00, 8'h00, ref_mac(255, 0, 0));

    // Backpressure: result held while i_ready is low, operand activity ignored.
    start_op(8'h0A, 8'h0C, 8'h03);
    wait_done(0, lat);
    check("bp_latency", 32'(lat), 32'(W));
    for (int i = 0; i < 5; i++) begin
      i_valid        = 1'($urandom);
      i_multiplicand = W'($urandom);
      i_multiplier   = W'($urandom);
      i_addend       = W'($urandom);
      @(posedge i_clk);
      @(negedge i_clk);
      check("bp_valid_hold", 32'(o_valid), 32'd1);
      check("bp_product_hold", 32'(o_product), 32'h007B);
    end
    i_valid = 1'b0;
    $display("op backpressure: product %04h held 5 cycles", o_product);
    finish_op();

    // Busy ignore: new operands presented during RUN must not be latched.
    start_op(8'h0A, 8'h0C, 8'h03);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid        = 1'b1;
    i_multiplicand = 8'h33;
    i_multiplier   = 8'h44;
    i_addend       = 8'h55;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    wait_done(2, lat);
    check("busy_ign_latency", 32'(lat), 32'(W));
    check("busy_ign_product", 32'(o_product), 32'h007B);
    $display("op busy_ignore: product %04h", o_product);
    finish_op();
    for (int i = 0; i < W + 3; i++) begin
      @(negedge i_clk);
      check("no_second_result", 32'(o_valid), 32'd0);
    end

    // Asynchronous reset in the middle of RUN.
    start_op(8'hFF, 8'hFF, 8'hFF);
    repeat (4) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    #2 i_reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd1);
    check("midrst_product", 32'(o_product), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    $display("op mid_reset: outputs cleared");
    @(negedge i_clk);
    i_reset_n = 1'b1;
    run_op("after_reset", 8'h0A, 8'h0C, 8'h03, ref_mac(10, 12, 3));

    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = W'($urandom);
      run_op("random", a, b, c, ref_mac(int'(a), int'(b), int'(c)));
    end

    // Round trip: divisor*quotient+remainder must rebuild the dividend.
    for (int i = 0; i < 256; i++) begin
      dividend = int'($urandom_range(0, 255));
      divisor  = int'($urandom_range(1, 255));
      quot     = dividend / divisor;
      rem      = dividend % divisor;
      run_op("roundtrip", W'(divisor), W'(quot), W'(rem), (2*W)'(dividend));
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
